// File: rtl/axi_ram_pkg.sv
// Shared AXI read-channel constants and the read controller's state encoding.
package axi_ram_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi_ram_read_ctrl_if.sv
// AXI4 read-address and read-data channel bundle between an AXI master and the RAM read controller.
interface axi_ram_read_ctrl_if #(
    parameter int ID_WIDTH       = 8,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 64
);
    logic [ID_WIDTH-1:0]       arid;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;
    logic [ID_WIDTH-1:0]       rid;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rdata_fifo.sv
// Two-entry synchronous FIFO holding {last, data} beats waiting for the R channel.
module axi_rdata_fifo #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);
    logic [WIDTH-1:0] mem_p1 [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       level;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (level == 2'd0);
    assign full    = (level == 2'd2);
    assign count   = level;
    assign head    = mem_p1[rd_ptr];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
        end
    end

    // Storage is data only; empty masks whatever it holds after reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem_p1[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/axi_ram_read_ctrl.sv
// AXI4 read slave: splits one AR burst at a time into single-word RAM reads and
// returns the 1-cycle-latency RAM data on R through a 2-entry skid FIFO.
module axi_ram_read_ctrl
    import axi_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_DEPTH      = 256,
    parameter int MEM_ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ID_WIDTH       = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    axi_ram_read_ctrl_if.slave        s_axi,
    output logic [MEM_ADDR_WIDTH-1:0] ram_read_addr,
    output logic                      ram_read_enable,
    input  logic [DATA_WIDTH-1:0]     ram_read_data
);
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_WORD = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);

    rd_state_t                 state;
    rd_state_t                 state_nxt;
    logic                      arready_r;
    logic [ID_WIDTH-1:0]       rid_r;
    logic [MEM_ADDR_WIDTH-1:0] addr_r;
    logic [8:0]                remaining;
    logic                      fixed;
    logic                      vld_p1;
    logic                      last_p1;
    logic                      ar_hs;
    logic                      r_hs;
    logic                      issue;
    logic [2:0]                occupancy;
    logic [DATA_WIDTH:0]       head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [1:0]                fifo_count;
    logic                      unused_ok;

    assign ar_hs = s_axi.arvalid & arready_r;
    assign r_hs  = ~fifo_empty & s_axi.rready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            arready_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            arready_r <= (state_nxt == IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ar_hs) state_nxt = BURST;
            BURST:   if (r_hs && head[DATA_WIDTH]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Issue only when the beat it produces is guaranteed a FIFO slot.
    always_comb begin
        occupancy = {1'b0, fifo_count} + {2'b00, vld_p1} - {2'b00, r_hs};
        issue     = (state == BURST) && (remaining != 9'd0) && (occupancy < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rid_r     <= '0;
            addr_r    <= '0;
            remaining <= 9'd0;
            fixed     <= 1'b0;
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
        end else begin
            vld_p1  <= issue;
            last_p1 <= issue && (remaining == 9'd1);
            if (ar_hs) begin
                rid_r     <= s_axi.arid;
                addr_r    <= s_axi.araddr[MEM_ADDR_WIDTH+BYTE_SHIFT-1:BYTE_SHIFT];
                remaining <= {1'b0, s_axi.arlen} + 9'd1;
                fixed     <= (s_axi.arburst == AXI_BURST_FIXED);
            end else if (issue) begin
                remaining <= remaining - 9'd1;
                if (!fixed) addr_r <= (addr_r == LAST_WORD) ? '0 : addr_r + 1'b1;
            end
        end
    end

    // Stage p1 -> FIFO: RAM data lands the cycle after the read was issued.
    axi_rdata_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_p1),
        .push_data ({last_p1, ram_read_data}),
        .pop       (r_hs),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign ram_read_enable = issue;
    assign ram_read_addr   = addr_r;
    assign s_axi.arready   = arready_r;
    assign s_axi.rvalid    = ~fifo_empty;
    assign s_axi.rdata     = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
    assign s_axi.rlast     = ~fifo_empty & head[DATA_WIDTH];
    assign s_axi.rid       = rid_r;
    assign s_axi.rresp     = AXI_RESP_OKAY;

    assign unused_ok = ^{s_axi.arsize, s_axi.araddr[BYTE_SHIFT-1:0],
                         s_axi.araddr[AXI_ADDR_WIDTH-1:MEM_ADDR_WIDTH+BYTE_SHIFT], fifo_full};
endmodule

// File: tb/tb_axi_ram_read_ctrl.sv
// Directed bench for axi_ram_read_ctrl with a behavioural 1-cycle-latency RAM.
module tb_axi_ram_read_ctrl;
    import axi_ram_pkg::*;

    localparam int DW    = 64;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_ram_read_ctrl_if #(.ID_WIDTH(8), .AXI_ADDR_WIDTH(32), .DATA_WIDTH(DW)) axi ();

    logic [AW-1:0] ram_read_addr;
    logic          ram_read_enable;
    logic [DW-1:0] ram_read_data;

    axi_ram_read_ctrl #(
        .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .AXI_ADDR_WIDTH(32), .ID_WIDTH(8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axi           (axi),
        .ram_read_addr   (ram_read_addr),
        .ram_read_enable (ram_read_enable),
        .ram_read_data   (ram_read_data)
    );

    logic [DW-1:0] mem [DEPTH];
    int n_total = 0;
    int n_bad   = 0;

    // RAM returns garbage when not enabled so no hold behaviour can be relied on.
    always @(posedge clk)
        ram_read_data <= ram_read_enable ? mem[ram_read_addr] : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Independent occupancy model: beats in flight vs. buffered.
    int   occ_m  = 0;
    logic pend_m = 1'b0;
    logic mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_read_enable)
                check("issue_room",
                      64'((occ_m + int'(pend_m) - int'(axi.rvalid & axi.rready)) < 2), 64'd1);
            check("rvalid_model", 64'(axi.rvalid), 64'(occ_m != 0));
            if (!rst_n) begin
                occ_m  <= 0;
                pend_m <= 1'b0;
            end else begin
                occ_m  <= occ_m + int'(pend_m) - int'(axi.rvalid & axi.rready);
                pend_m <= ram_read_enable;
            end
        end
    end

    function automatic logic pick_ready(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc - 1) % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int rmode);
        logic [AW-1:0] w;
        logic [AW-1:0] ew;
        logic          fx;
        int            k, n_iss, cyc, beats;
        w     = addr[AW+2:3];
        fx    = (burst == AXI_BURST_FIXED);
        beats = int'(len) + 1;
        @(posedge clk); #1;
        axi.arid = id; axi.araddr = addr; axi.arlen = len; axi.arburst = burst;
        axi.arvalid = 1'b1; axi.rready = 1'b0;
        @(negedge clk);
        check("ar_ready", 64'(axi.arready), 64'd1);
        k = 0; n_iss = 0; cyc = 0;
        while (k < beats && cyc < 4000) begin
            @(posedge clk); #1;
            axi.arvalid = 1'b0;
            cyc++;
            axi.rready = pick_ready(rmode, cyc);
            @(negedge clk);
            check("ar_ready_low", 64'(axi.arready), 64'd0);
            if (ram_read_enable) begin
                ew = fx ? w : w + AW'(n_iss);
                check("issue_addr", 64'(ram_read_addr), 64'(ew));
                if (rmode == 0) check("issue_cyc", 64'(cyc), 64'(n_iss + 1));
                n_iss++;
            end
            if (axi.rvalid) begin
                ew = fx ? w : w + AW'(k);
                check("rdata", axi.rdata, mem[ew]);
                check("rlast", 64'(axi.rlast), 64'(k == beats - 1));
                check("rid", 64'(axi.rid), 64'(id));
                check("rresp", 64'(axi.rresp), 64'(AXI_RESP_OKAY));
                if (rmode == 0) check("beat_cyc", 64'(cyc), 64'(k + 3));
                if (axi.rready) k++;
            end
        end
        check("beat_count", 64'(k), 64'(beats));
        check("issue_count", 64'(n_iss), 64'(beats));
        @(posedge clk); #1;
        @(negedge clk);
        check("ar_ready_back", 64'(axi.arready), 64'd1);
        check("rvalid_idle", 64'(axi.rvalid), 64'd0);
        check("ren_idle", 64'(ram_read_enable), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d", n_total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, cyc;
        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd3;
        axi.arburst = AXI_BURST_INCR; axi.arvalid = 1'b0; axi.rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = {32'hC0DE_0000 | 32'(i), ~32'(i * 13)};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_arready", 64'(axi.arready), 64'd0);
        check("rst_rvalid", 64'(axi.rvalid), 64'd0);
        check("rst_rlast", 64'(axi.rlast), 64'd0);
        check("rst_ren", 64'(ram_read_enable), 64'd0);
        check("rst_raddr", 64'(ram_read_addr), 64'd0);
        check("rst_rdata", axi.rdata, 64'd0);
        check("rst_rid", 64'(axi.rid), 64'd0);
        check("rst_rresp", 64'(axi.rresp), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("arready_pre_rise", 64'(axi.arready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("arready_rise", 64'(axi.arready), 64'd1);

        run_burst(8'h5A, 32'h0000_0040, 8'd0,   AXI_BURST_INCR,  0);
        run_burst(8'h11, 32'h0000_0100, 8'd15,  AXI_BURST_INCR,  0);
        run_burst(8'h22, 32'h0000_0200, 8'd7,   AXI_BURST_INCR,  1);
        run_burst(8'h33, 32'h0000_07F0, 8'd3,   AXI_BURST_INCR,  0);
        run_burst(8'h44, 32'h0000_0050, 8'd3,   AXI_BURST_FIXED, 0);
        run_burst(8'h77, 32'h0000_002B, 8'd2,   2'b11,           1);
        run_burst(8'h99, 32'hABC0_0325, 8'd255, AXI_BURST_INCR,  2);

        // Reset in the middle of an 8-beat burst.
        @(posedge clk); #1;
        axi.arid = 8'h66; axi.araddr = 32'd160; axi.arlen = 8'd7;
        axi.arburst = AXI_BURST_INCR; axi.arvalid = 1'b1; axi.rready = 1'b1;
        @(negedge clk);
        check("mid_ar_ready", 64'(axi.arready), 64'd1);
        k = 0; cyc = 0;
        while (k < 2 && cyc < 100) begin
            @(posedge clk); #1 axi.arvalid = 1'b0;
            cyc++;
            @(negedge clk);
            if (axi.rvalid && axi.rready) k++;
        end
        check("mid_beats_before", 64'(k), 64'd2);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rvalid", 64'(axi.rvalid), 64'd0);
        check("mid_ren", 64'(ram_read_enable), 64'd0);
        check("mid_arready", 64'(axi.arready), 64'd0);
        check("mid_rid", 64'(axi.rid), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_arready", 64'(axi.arready), 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("post_rst_arready", 64'(axi.arready), 64'd1);
            check("post_rst_rvalid", 64'(axi.rvalid), 64'd0);
            check("post_rst_ren", 64'(ram_read_enable), 64'd0);
        end
        run_burst(8'hA7, 32'h0000_0018, 8'd0, AXI_BURST_INCR, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
